// File: rtl/hdlc_line_monitor.sv
// HDLC line monitor: flag/abort/idle detection, zero destuffing and frame length
// measurement with start-window, length and alignment checks plus statistics.
module hdlc_line_monitor #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MIN_BITS  = 32,
  parameter int unsigned MAX_BITS  = 4096,
  parameter int unsigned START_WIN = 2,
  parameter int unsigned IDLE_ONES = 15
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             bit_en_i,
  input  logic             line_i,
  input  logic             frame_i,
  input  logic             abort_i,
  input  logic             clr_i,
  output logic             flag_o,
  output logic             abort_o,
  output logic             idle_o,
  output logic             in_frame_o,
  output logic             frame_end_o,
  output logic [CNT_W-1:0] frame_len_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] abort_cnt_o,
  output logic             err_o,
  output logic [3:0]       err_code_o
);

  localparam int unsigned OW = $clog2(IDLE_ONES + 1);
  localparam int unsigned WW = $clog2(START_WIN + 1);
  localparam int unsigned LW = CNT_W + 1;

  localparam logic [OW-1:0] ONES_SAT = OW'(IDLE_ONES);
  localparam logic [OW-1:0] ONES_5   = OW'(5);
  localparam logic [OW-1:0] ONES_6   = OW'(6);
  localparam logic [OW-1:0] ONES_7   = OW'(7);

  typedef enum logic [1:0] {HUNT, FLAG, DATA} state_t;

  state_t           state, state_n;
  logic [OW-1:0]    ones_run, ones_n;
  logic             zero_pend, zp_n;
  logic [LW-1:0]    cnt, cnt_n, add, sum;
  logic             frame_q, armed, arm_n, rise;
  logic [WW-1:0]    win, win_n;
  logic             flag_det, abort_det, fend, abort_in_frame;
  logic [3:0]       err_new;
  logic [CNT_W-1:0] len_n;

  always_comb begin
    state_n        = state;
    ones_n         = ones_run;
    zp_n           = zero_pend;
    cnt_n          = cnt;
    arm_n          = armed;
    win_n          = win;
    len_n          = frame_len_o;
    add            = '0;
    flag_det       = 1'b0;
    abort_det      = 1'b0;
    fend           = 1'b0;
    abort_in_frame = 1'b0;
    err_new        = '0;

    // A 0 bit commits the pending zero and the ones before it; the zero just
    // received stays pending because it may turn out to be a flag's leading 0.
    if (bit_en_i) begin
      if (line_i) begin
        if (ones_run != ONES_SAT) ones_n = ones_run + 1'b1;
        abort_det = (ones_run == ONES_6);
      end else begin
        ones_n = '0;
        if (ones_run == ONES_5) begin
          add  = LW'(zero_pend) + LW'(5);
          zp_n = 1'b0;
        end else if (ones_run == ONES_6) begin
          flag_det = 1'b1;
          zp_n     = 1'b0;
        end else if (ones_run >= ONES_7) begin
          zp_n = 1'b0;
        end else begin
          add  = LW'(zero_pend) + LW'(ones_run);
          zp_n = 1'b1;
        end
      end
    end

    sum = cnt + add;

    if (bit_en_i) begin
      case (state)
        HUNT: begin
          if (flag_det) begin
            state_n = FLAG;
            cnt_n   = '0;
          end
        end
        FLAG: begin
          if (abort_det) begin
            state_n = HUNT;
            cnt_n   = '0;
          end else if (flag_det) begin
            cnt_n = '0;
          end else if (sum != '0) begin
            state_n = DATA;
            cnt_n   = sum;
          end
        end
        DATA: begin
          if (abort_det) begin
            state_n        = HUNT;
            cnt_n          = '0;
            abort_in_frame = 1'b1;
          end else if (flag_det) begin
            state_n    = FLAG;
            cnt_n      = '0;
            fend       = 1'b1;
            len_n      = cnt[CNT_W-1:0];
            err_new[1] = (cnt < LW'(MIN_BITS));
            err_new[3] = (cnt[2:0] != 3'd0);
          end else if (sum > LW'(MAX_BITS)) begin
            state_n    = HUNT;
            cnt_n      = '0;
            err_new[2] = 1'b1;
          end else begin
            cnt_n = sum;
          end
        end
        default: begin
          state_n = HUNT;
          cnt_n   = '0;
        end
      endcase
    end

    rise = frame_i & ~frame_q & ~abort_i;
    if (rise) begin
      arm_n = 1'b1;
      win_n = WW'(START_WIN);
    end else if (armed) begin
      if (abort_i) begin
        arm_n = 1'b0;
      end else if (bit_en_i) begin
        if (flag_det) begin
          arm_n = 1'b0;
        end else if (win == WW'(1)) begin
          arm_n      = 1'b0;
          err_new[0] = 1'b1;
        end else begin
          win_n = win - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= HUNT;
      ones_run    <= '0;
      zero_pend   <= 1'b0;
      cnt         <= '0;
      frame_q     <= 1'b0;
      armed       <= 1'b0;
      win         <= '0;
      flag_o      <= 1'b0;
      abort_o     <= 1'b0;
      frame_end_o <= 1'b0;
      frame_len_o <= '0;
      frame_cnt_o <= '0;
      abort_cnt_o <= '0;
      err_code_o  <= '0;
    end else begin
      state       <= state_n;
      ones_run    <= ones_n;
      zero_pend   <= zp_n;
      cnt         <= cnt_n;
      frame_q     <= frame_i;
      armed       <= arm_n;
      win         <= win_n;
      flag_o      <= flag_det;
      abort_o     <= abort_det;
      frame_end_o <= fend;
      frame_len_o <= len_n;
      if (clr_i) begin
        frame_cnt_o <= '0;
        abort_cnt_o <= '0;
        err_code_o  <= '0;
      end else begin
        if (fend && frame_cnt_o != '1) frame_cnt_o <= frame_cnt_o + 1'b1;
        if (abort_in_frame && abort_cnt_o != '1) abort_cnt_o <= abort_cnt_o + 1'b1;
        err_code_o <= err_code_o | err_new;
      end
    end
  end

  assign idle_o     = (ones_run == ONES_SAT);
  assign in_frame_o = (state == DATA);
  assign err_o      = |err_code_o;

endmodule

// File: doc/hdlc_line_monitor.md
Name: hdlc_line_monitor

Overview:
- Synthesisable, parametrised HDLC line monitor.
- Samples one serial HDLC bit stream (Tx or Rx side) on a bit strobe.
- Detects flags, aborts and idle; removes stuffed zeros; measures frame length.
- Checks the frame-start window, minimum/maximum length and octet alignment; keeps saturating statistics counters and sticky error bits.
- Instantiated beside the Tx and Rx paths for in-system checking and as a reusable bench monitor.

Parameters:
CNT_W, 16, width of frame_len_o and both statistics counters
MIN_BITS, 32, minimum legal destuffed frame length in bits (inclusive)
MAX_BITS, 4096, maximum legal destuffed frame length in bits (inclusive, < 2^CNT_W)
START_WIN, 2, strobed bits after frame_i rises within which a flag must complete
IDLE_ONES, 15, consecutive ones that assert idle_o

Ports:
clk_i  in  1  system clock
rstn_i  in  1  reset; asynchronous, active-low
bit_en_i  in  1  line sample strobe, one clk_i cycle per bit
line_i  in  1  serial HDLC line, valid when bit_en_i=1
frame_i  in  1  transmitter frame request (start-window check)
abort_i  in  1  transmitter abort request (suppresses start check)
clr_i  in  1  synchronous clear of counters and sticky errors
flag_o  out  1  pulse: flag completed
abort_o  out  1  pulse: 7th consecutive one seen
idle_o  out  1  level: ones run >= IDLE_ONES
in_frame_o  out  1  level: state DATA
frame_end_o  out  1  pulse: closing flag of a frame
frame_len_o  out  CNT_W  destuffed data bits of last frame
frame_cnt_o  out  CNT_W  frames ended (saturating)
abort_cnt_o  out  CNT_W  aborts inside a frame (saturating)
err_o  out  1  OR of err_code_o
err_code_o  out  4  sticky: [0] start timeout, [1] runt, [2] oversize, [3] non-octet

Behaviour:
- Reset: all outputs 0, state HUNT, ones_run=0, cnt=0, zero_pend=0.
- All logic advances only on bit_en_i=1, except clr_i and the frame_i edge detector.
- Pulses last 1 clk_i cycle and appear the cycle after the qualifying bit_en_i cycle.
- ones_run saturates at IDLE_ONES; reset to 0 by any 0 bit.
- Bit classification:
  - 1 bit: ones_run++.
  - 0 bit, ones_run==5: stuffed zero. cnt += zero_pend+5; zero_pend=0.
  - 0 bit, ones_run==6: flag (shared-zero flags are also detected). zero_pend=0.
  - 0 bit, otherwise: cnt += zero_pend+ones_run; zero_pend=1.
  - 0 bit, ones_run>=7: return to HUNT, no flag.
- Flag data exclusion: the flag's leading 0 and its six ones are never counted as data.
- Abort: ones_run reaching 7 pulses abort_o once per run.
- idle_o is high while ones_run>=IDLE_ONES.
- State machine:
  - HUNT -> FLAG on flag.
  - FLAG -> FLAG on flag, with no frame_end_o.
  - FLAG -> DATA when cnt becomes nonzero.
  - FLAG/DATA -> HUNT on abort; if in DATA, abort_cnt++ and no frame_end_o.
  - DATA -> FLAG on flag:
    - frame_end_o=1; frame_len_o=cnt (held until the next frame end); frame_cnt++.
    - err[1] if cnt<MIN_BITS; err[3] if cnt[2:0]!=0.
  - DATA -> HUNT when cnt exceeds MAX_BITS: err[2], no frame_end_o.
  - cnt is cleared on every state entry.
- Start check:
  - A rising edge of frame_i, sampled on clk_i while abort_i=0, arms a window of START_WIN strobes.
  - The first strobe is the first bit_en_i after the edge.
  - A flag on any strobe in the window disarms it.
  - Expiry sets err[0].
  - abort_i=1 at any point in the window disarms it.
  - A new edge while armed restarts the window.
- Counters saturate at all-ones.
- clr_i clears frame_cnt_o, abort_cnt_o and err_code_o; a same-cycle increment or error is lost.
- clr_i does not affect state, frame_len_o or pulses.
- Async reset mid-frame aborts silently: no pulses, everything returns to reset values.

Test Plan:
- Flag, data 0xA5 0x3C LSB-first, flag -> one frame_end_o, frame_len_o=16, frame_cnt_o=1, err_code_o=0 (MIN_BITS=16).
- Flag, data 0xFF (line 11111 0 111), flag -> stuffed zero removed, frame_len_o=8; flag_o pulses twice.
- Flag, 10 data bits, then 7 ones -> abort_o one pulse, abort_cnt_o=1, no frame_end_o, in_frame_o=0; following 8 ones do not re-pulse abort_o.
- Frame of 12 bits (MIN_BITS=32) -> frame_end_o, frame_len_o=12, err_code_o=4'b1010, err_o=1; then clr_i -> err_code_o=0, frame_cnt_o=0.
- frame_i rises with abort_i=0, no flag for 2 strobes -> err_code_o[0]=1.
- Same with abort_i=1 -> err_code_o[0]=0.
- Line held 1 for 20 strobes -> idle_o from the 15th; rstn_i low mid-frame -> all outputs 0 immediately.
